radar_signal_conditioner: RTL
=============================

Name: radar_signal_conditioner

Overview:
Front-end for the raw radar timing inputs: ARP (antenna reference pulse), ACP (azimuth change pulse) and TRIG (transmit trigger). Sits directly upstream of radar_statistics and of every other consumer of these signals. Per channel it applies a polarity fix, a synchronizer, a stable-count glitch filter and an edge detector. It drives clean levels, which radar_statistics consumes as ARP/ACP/TRIG, plus single-cycle edge strobes.

Parameters:
SYNC_STAGES, 2, synchronizer flops per channel (legal values 2..4).
FILT_WIDTH, 4, width of each stability counter.
ARP_FILT, 3, consecutive stable cycles required before ARP_LVL changes (0..2^FILT_WIDTH-1).
ACP_FILT, 2, same for ACP.
TRIG_FILT, 1, same for TRIG.
INVERT, 3'b000, per-channel input inversion; bit0 ARP, bit1 ACP, bit2 TRIG.

Ports:
US_CLK  input  1  1 MHz sample clock, shared with radar_statistics.
RST  input  1  synchronous reset, active-high.
ARP_IN  input  1  raw asynchronous ARP.
ACP_IN  input  1  raw asynchronous ACP.
TRIG_IN  input  1  raw asynchronous TRIG.
ARP_LVL  output  1  filtered ARP level.
ACP_LVL  output  1  filtered ACP level.
TRIG_LVL  output  1  filtered TRIG level.
ARP_RISE  output  1  one-cycle strobe on an ARP_LVL 0->1 transition.
ACP_RISE  output  1  one-cycle strobe on an ACP_LVL 0->1 transition.
TRIG_RISE  output  1  one-cycle strobe on a TRIG_LVL 0->1 transition.
ARP_FALL  output  1  one-cycle strobe on an ARP_LVL 1->0 transition.

Behaviour:
- Clocking and reset: one clock, US_CLK. Reset is synchronous and active-high on RST.
- Values held while RST=1: all *_LVL, *_RISE, *_FALL outputs 0; synchronizer flops 0; counters 0; every channel FSM in STABLE_LO.
- Input path: raw input XOR INVERT[ch], then the SYNC_STAGES flop chain. The synced value is s.
- Channel FSM states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
- STABLE_LO with s=1: if FILT=0, go to STABLE_HI directly; else go to QUAL_HI with cnt=1.
- QUAL_HI: s=1 and cnt==FILT goes to STABLE_HI; s=1 and cnt<FILT increments cnt; s=0 returns to STABLE_LO and counts a glitch.
- STABLE_HI and QUAL_LO mirror STABLE_LO and QUAL_HI.
- LVL is 1 in STABLE_HI and in QUAL_LO, and 0 otherwise.
- LVL, RISE and FALL are registered outputs. RISE/FALL assert in the same cycle that LVL changes, for exactly one cycle.
- Latency: with a raw input held stable from clock edge 0, LVL changes at edge SYNC_STAGES+FILT. With defaults: ARP at edge 5, ACP at 4, TRIG at 3.
- Pulse filtering: a raw pulse shorter than FILT+1 cycles never changes LVL. Minimum pass width is FILT+1 cycles.
- Counter width: cnt never exceeds FILT, so there is no wrap-around. FILT values that do not fit in FILT_WIDTH are a synthesis-time error (generate check).
- Channels are fully independent. Simultaneous edges on all three inputs produce simultaneous strobes, subject to each channel's own FILT.
- Reset mid-qualification: the candidate transition is discarded and no strobe is emitted. After reset release, an input already high needs the full latency before LVL rises.

Optional Feature:
Macro: RADAR_COND_GLITCH_CNT_EN.
- Defined:
  - Adds three outputs, ARP_GLITCH, ACP_GLITCH and TRIG_GLITCH, each 16 bits.
  - Each is a saturating count (stops at 16'hFFFF) of abandoned QUAL_HI/QUAL_LO qualifications on that channel.
  - Each count is cleared by RST.
  - Each count is also cleared in the cycle of the channel's own RISE strobe. For ARP this gives glitches per antenna revolution.
  - A clear and an abandoned qualification in the same cycle gives a count of 1.
- Undefined: the ports and the counters are absent. The remaining behaviour is identical.

Decomposition:
- Package radar_cond_pkg:
  - Channel index constants CH_ARP=0, CH_ACP=1, CH_TRIG=2.
  - 2-bit filter state encoding: STABLE_LO=0, QUAL_HI=1, STABLE_HI=2, QUAL_LO=3.
  - GLITCH_WIDTH=16.
- Sub-module radar_signal_filter:
  - Parameters SYNC_STAGES, FILT_WIDTH, FILT, INVERT.
  - Ports US_CLK, RST, RAW_IN, LVL, RISE, FALL, and GLITCH when the macro is defined.
  - Instantiated three times by the top level.

Test Plan:
1. Reset with ARP_IN=1 held, release at edge 0, defaults -> ARP_LVL=1 and ARP_RISE=1 at edge 5 only. ACP and TRIG outputs stay 0.
2. ACP_IN high pulse of 2 cycles (ACP_FILT=2) -> ACP_LVL stays 0 and ACP_GLITCH=1. Pulse of 3 cycles -> ACP_LVL high for 3 cycles starting at edge 4 after the rising input.
3. Toggle TRIG_IN every 50 cycles for 20 periods -> 20 TRIG_RISE strobes, each 3 cycles after the input edge, and TRIG_GLITCH=0.
4. INVERT=3'b001, ARP_IN held 0 after reset -> ARP_LVL=1 at edge 5. Later ARP_IN=1 for 10 cycles -> ARP_FALL one cycle, ARP_LVL=0 for 10 cycles.
5. Assert RST during QUAL_HI (ARP_IN high 2 cycles, then RST for 1 cycle) -> no ARP_RISE. After release, ARP_LVL rises exactly 5 edges later.
6. All three inputs rise on the same edge -> TRIG_RISE at +3, ACP_RISE at +4, ARP_RISE at +5.

Source files
------------

// File: rtl/radar_signal_conditioner_pkg.sv
// Shared constants for the radar timing-input conditioner.
// Channel indices, filter state encoding and glitch counter width.
package radar_cond_pkg;

    localparam int CH_ARP  = 0;
    localparam int CH_ACP  = 1;
    localparam int CH_TRIG = 2;

    localparam int GLITCH_WIDTH = 16;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } filt_state_e;

    function automatic logic [GLITCH_WIDTH-1:0] sat_inc(
        input logic [GLITCH_WIDTH-1:0] v
    );
        return (&v) ? v : v + GLITCH_WIDTH'(1);
    endfunction

endpackage

// File: rtl/radar_signal_conditioner_if.sv
// Signal bundle for radar_signal_conditioner: raw inputs and clean outputs.
// master drives the raw inputs; slave is the conditioner's view.
// Glitch count signals exist only with RADAR_COND_GLITCH_CNT_EN.
interface radar_signal_conditioner_if;
    import radar_cond_pkg::*;

    logic ARP_IN;
    logic ACP_IN;
    logic TRIG_IN;
    logic ARP_LVL;
    logic ACP_LVL;
    logic TRIG_LVL;
    logic ARP_RISE;
    logic ACP_RISE;
    logic TRIG_RISE;
    logic ARP_FALL;
`ifdef RADAR_COND_GLITCH_CNT_EN
    logic [GLITCH_WIDTH-1:0] ARP_GLITCH;
    logic [GLITCH_WIDTH-1:0] ACP_GLITCH;
    logic [GLITCH_WIDTH-1:0] TRIG_GLITCH;
`endif

    modport master (
        output ARP_IN, ACP_IN, TRIG_IN,
        input  ARP_LVL, ACP_LVL, TRIG_LVL,
        input  ARP_RISE, ACP_RISE, TRIG_RISE, ARP_FALL
`ifdef RADAR_COND_GLITCH_CNT_EN
        , input ARP_GLITCH, ACP_GLITCH, TRIG_GLITCH
`endif
    );

    modport slave (
        input  ARP_IN, ACP_IN, TRIG_IN,
        output ARP_LVL, ACP_LVL, TRIG_LVL,
        output ARP_RISE, ACP_RISE, TRIG_RISE, ARP_FALL
`ifdef RADAR_COND_GLITCH_CNT_EN
        , output ARP_GLITCH, ACP_GLITCH, TRIG_GLITCH
`endif
    );

endinterface

// File: rtl/radar_signal_filter.sv
// One conditioner channel: polarity fix, synchronizer, stable-count
// glitch filter and edge strobes.
// Ports: US_CLK, RST (sync, active-high), RAW_IN, LVL, RISE, FALL,
// GLITCH (saturating abandoned-qualification count, only when
// RADAR_COND_GLITCH_CNT_EN is defined).
module radar_signal_filter
    import radar_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_WIDTH  = 4,
    parameter int FILT        = 1,
    parameter bit INVERT      = 1'b0
) (
    input  logic US_CLK,
    input  logic RST,
    input  logic RAW_IN,
    output logic LVL,
    output logic RISE,
    output logic FALL
`ifdef RADAR_COND_GLITCH_CNT_EN
    ,
    output logic [GLITCH_WIDTH-1:0] GLITCH
`endif
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (FILT < 0 || FILT > (1 << FILT_WIDTH) - 1) begin : g_bad_filt
        $error("FILT does not fit in FILT_WIDTH");
    end

    localparam logic [FILT_WIDTH-1:0] FILT_C = FILT_WIDTH'(FILT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    filt_state_e            state_q, state_d;
    logic [FILT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge US_CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RAW_IN ^ INVERT};
        end
    end

    // cnt counts cycles already seen at the candidate level; it never
    // exceeds FILT so it cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    if (FILT == 0) begin
                        state_d = STABLE_HI;
                    end else begin
                        state_d = QUAL_HI;
                        cnt_d   = FILT_WIDTH'(1);
                    end
                end
            end
            QUAL_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_C) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + FILT_WIDTH'(1);
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (FILT == 0) begin
                        state_d = STABLE_LO;
                    end else begin
                        state_d = QUAL_LO;
                        cnt_d   = FILT_WIDTH'(1);
                    end
                end
            end
            QUAL_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_C) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + FILT_WIDTH'(1);
                end
            end
        endcase
        lvl_d  = (state_d == STABLE_HI) || (state_d == QUAL_LO);
        rise_d = lvl_d & ~lvl_q;
        fall_d = ~lvl_d & lvl_q;
    end

    always_ff @(posedge US_CLK) begin
        if (RST) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign LVL  = lvl_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

`ifdef RADAR_COND_GLITCH_CNT_EN
    logic                    abandon;
    logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;

    assign abandon = (state_q == QUAL_HI && !s) ||
                     (state_q == QUAL_LO && s);

    // The count restarts on each RISE; an abandon in that same cycle
    // is kept as the first count of the new window.
    always_comb begin
        glitch_d = glitch_q;
        if (rise_d) begin
            glitch_d = GLITCH_WIDTH'(abandon);
        end else if (abandon) begin
            glitch_d = sat_inc(glitch_q);
        end
    end

    always_ff @(posedge US_CLK) begin
        if (RST) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign GLITCH = glitch_q;
`endif

endmodule

// File: rtl/radar_signal_conditioner.sv
// Conditions raw ARP, ACP and TRIG into clean levels and edge strobes.
// Ports: US_CLK, RST (sync, active-high), *_IN raw, *_LVL, *_RISE,
// ARP_FALL; *_GLITCH counts only when RADAR_COND_GLITCH_CNT_EN is defined.
module radar_signal_conditioner
    import radar_cond_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_WIDTH  = 4,
    parameter int         ARP_FILT    = 3,
    parameter int         ACP_FILT    = 2,
    parameter int         TRIG_FILT   = 1,
    parameter logic [2:0] INVERT      = 3'b000
) (
    input  logic US_CLK,
    input  logic RST,
    input  logic ARP_IN,
    input  logic ACP_IN,
    input  logic TRIG_IN,
    output logic ARP_LVL,
    output logic ACP_LVL,
    output logic TRIG_LVL,
    output logic ARP_RISE,
    output logic ACP_RISE,
    output logic TRIG_RISE,
    output logic ARP_FALL
`ifdef RADAR_COND_GLITCH_CNT_EN
    ,
    output logic [GLITCH_WIDTH-1:0] ARP_GLITCH,
    output logic [GLITCH_WIDTH-1:0] ACP_GLITCH,
    output logic [GLITCH_WIDTH-1:0] TRIG_GLITCH
`endif
);

    // Only ARP has a consumer for its falling strobe.
    logic acp_fall;
    logic trig_fall;

    radar_signal_filter #(
        .SYNC_STAGES(SYNC_STAGES), .FILT_WIDTH(FILT_WIDTH),
        .FILT(ARP_FILT), .INVERT(INVERT[CH_ARP])
    ) u_arp (
        .US_CLK(US_CLK), .RST(RST), .RAW_IN(ARP_IN),
        .LVL(ARP_LVL), .RISE(ARP_RISE), .FALL(ARP_FALL)
`ifdef RADAR_COND_GLITCH_CNT_EN
        , .GLITCH(ARP_GLITCH)
`endif
    );

    radar_signal_filter #(
        .SYNC_STAGES(SYNC_STAGES), .FILT_WIDTH(FILT_WIDTH),
        .FILT(ACP_FILT), .INVERT(INVERT[CH_ACP])
    ) u_acp (
        .US_CLK(US_CLK), .RST(RST), .RAW_IN(ACP_IN),
        .LVL(ACP_LVL), .RISE(ACP_RISE), .FALL(acp_fall)
`ifdef RADAR_COND_GLITCH_CNT_EN
        , .GLITCH(ACP_GLITCH)
`endif
    );

    radar_signal_filter #(
        .SYNC_STAGES(SYNC_STAGES), .FILT_WIDTH(FILT_WIDTH),
        .FILT(TRIG_FILT), .INVERT(INVERT[CH_TRIG])
    ) u_trig (
        .US_CLK(US_CLK), .RST(RST), .RAW_IN(TRIG_IN),
        .LVL(TRIG_LVL), .RISE(TRIG_RISE), .FALL(trig_fall)
`ifdef RADAR_COND_GLITCH_CNT_EN
        , .GLITCH(TRIG_GLITCH)
`endif
    );

    logic unused_falls;
    assign unused_falls = acp_fall ^ trig_fall;

endmodule
